// File: rtl/ddr3_mon_pkg.sv
// Shared types and constants for the DDR3 command-bus monitor.
// Command encoding is the raw {ras_n, cas_n, we_n} triple seen on the bus.
package ddr3_mon_pkg;

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_MAX = 8'd255;

  // Default DDR3 timing for the sg125 speed grade (tCK 1.25 ns), in clocks.
  localparam int T_RCD_SG125 = 11;
  localparam int T_RP_SG125  = 11;
  localparam int T_RFC_SG125 = 208;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } ddr3_cmd_e;

  // Numeric value doubles as priority: lower non-zero code wins.
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_MULTI_CS  = 3'd1,
    ERR_IN_TRFC   = 3'd2,
    ERR_ACT_OPEN  = 3'd3,
    ERR_ACT_TRP   = 3'd4,
    ERR_RW_CLOSED = 3'd5,
    ERR_RW_TRCD   = 3'd6,
    ERR_REF_OPEN  = 3'd7
  } ddr3_err_e;

  // Timers count up and stick at TIMER_MAX. The same increment also gives the
  // elapsed-cycle count as seen by a command sampled on the current edge:
  // a timer cleared on edge k reads n-1 on edge k+n, so elapsed = next value.
  function automatic logic [TIMER_W-1:0] timer_next(input logic [TIMER_W-1:0] t);
    if (t == TIMER_MAX) return t;
    return t + 1'b1;
  endfunction

  // Timing limits larger than the timer range can never be observed, so they
  // are capped at the saturation value.
  function automatic logic [TIMER_W-1:0] timer_limit(input int cycles);
    if (cycles > 255) return TIMER_MAX;
    if (cycles < 0) return '0;
    return TIMER_W'(cycles);
  endfunction

  // Lowest set index of an 8-bank open mask, used to name a bank for REF_OPEN.
  function automatic logic [2:0] lowest_bank(input logic [7:0] mask);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddr3_mon_bank.sv
// Per-bank tracker: open flag plus cycles-since-ACT and cycles-since-PRE
// timers. Error candidates are raised against the state before this cycle's
// command is applied; the top level decides which one gets reported.
module ddr3_mon_bank
  import ddr3_mon_pkg::*;
#(
  parameter int T_RCD = T_RCD_SG125,
  parameter int T_RP  = T_RP_SG125
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_act,
  input  logic cmd_rw,
  input  logic cmd_close,
  input  logic upd_en,
  output logic is_open,
  output logic err_act_open,
  output logic err_act_trp,
  output logic err_rw_closed,
  output logic err_rw_trcd
);

  localparam logic [TIMER_W-1:0] RCD_LIM = timer_limit(T_RCD);
  localparam logic [TIMER_W-1:0] RP_LIM  = timer_limit(T_RP);

  logic [TIMER_W-1:0] act_tmr;
  logic [TIMER_W-1:0] pre_tmr;

  // Bank state: timers free-run to saturation, commands restart them.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_open <= 1'b0;
      act_tmr <= TIMER_MAX;
      pre_tmr <= TIMER_MAX;
    end else begin
      act_tmr <= timer_next(act_tmr);
      pre_tmr <= timer_next(pre_tmr);
      if (upd_en) begin
        if (cmd_act) begin
          is_open <= 1'b1;
          act_tmr <= '0;
        end
        if (cmd_close) begin
          is_open <= 1'b0;
          pre_tmr <= '0;
        end
      end
    end
  end

  assign err_act_open  = cmd_act & is_open;
  assign err_act_trp   = cmd_act & (timer_next(pre_tmr) < RP_LIM);
  assign err_rw_closed = cmd_rw & ~is_open;
  assign err_rw_trcd   = cmd_rw & (timer_next(act_tmr) < RCD_LIM);

endmodule

// File: rtl/ddr3_cmd_monitor.sv
// Passive DDR3 command/address bus monitor. Decodes commands per rank,
// tracks bank and refresh timing, counts traffic and reports at most one
// protocol violation per cycle. All outputs are registered.
module ddr3_cmd_monitor
  import ddr3_mon_pkg::*;
#(
  parameter int N_RANKS = 2,
  parameter int N_BANKS = 8,
  parameter int T_RCD   = T_RCD_SG125,
  parameter int T_RP    = T_RP_SG125,
  parameter int T_RFC   = T_RFC_SG125,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  c0_ddr3_addr,
  input  logic [2:0]                   c0_ddr3_ba,
  input  logic                         c0_ddr3_ras_n,
  input  logic                         c0_ddr3_cas_n,
  input  logic                         c0_ddr3_we_n,
  input  logic [N_RANKS-1:0]           c0_ddr3_cke,
  input  logic [N_RANKS-1:0]           c0_ddr3_cs_n,
  output logic                         err_valid,
  output logic [2:0]                   err_code,
  output logic                         err_rank,
  output logic [2:0]                   err_bank,
  output logic [N_RANKS*N_BANKS-1:0]   bank_open,
  output logic [CNT_W-1:0]             act_cnt,
  output logic [CNT_W-1:0]             rd_cnt,
  output logic [CNT_W-1:0]             wr_cnt,
  output logic [CNT_W-1:0]             ref_cnt
);

  localparam logic [TIMER_W-1:0] RFC_LIM = timer_limit(T_RFC);

  // ---------------------------------------------------------------- decode
  ddr3_cmd_e          bus_cmd;
  logic [N_RANKS-1:0] rank_sel;
  logic               is_act, is_rw, is_pre, is_ref, is_nop;
  logic               a10;
  logic [CNT_W-1:0]   n_sel;
  logic               multi_cs;
  logic               upd_en;
  logic               unused_addr_bits;

  assign bus_cmd  = ddr3_cmd_e'({c0_ddr3_ras_n, c0_ddr3_cas_n, c0_ddr3_we_n});
  assign rank_sel = ~c0_ddr3_cs_n & c0_ddr3_cke;
  assign is_act   = (bus_cmd == CMD_ACT);
  assign is_rw    = (bus_cmd == CMD_RD) || (bus_cmd == CMD_WR);
  assign is_pre   = (bus_cmd == CMD_PRE);
  assign is_ref   = (bus_cmd == CMD_REF);
  assign is_nop   = (bus_cmd == CMD_NOP);
  assign a10      = c0_ddr3_addr[10];

  // Row/column bits are irrelevant to protocol checking; only A10 matters.
  assign unused_addr_bits = ^{c0_ddr3_addr[15:11], c0_ddr3_addr[9:0]};

  // Number of ranks selected this cycle; also the counter increment.
  always_comb begin
    n_sel = '0;
    for (int r = 0; r < N_RANKS; r++) begin
      n_sel = n_sel + CNT_W'(rank_sel[r]);
    end
  end

  // A multi-rank ACT/RD/WR is treated as never having reached the DRAM.
  assign multi_cs = (n_sel > CNT_W'(1)) && (is_act || is_rw);
  assign upd_en   = ~multi_cs;

  // ------------------------------------------------------------- bank array
  logic [N_BANKS-1:0] open_q        [N_RANKS];
  logic [N_BANKS-1:0] c_act_open    [N_RANKS];
  logic [N_BANKS-1:0] c_act_trp     [N_RANKS];
  logic [N_BANKS-1:0] c_rw_closed   [N_RANKS];
  logic [N_BANKS-1:0] c_rw_trcd     [N_RANKS];

  for (genvar r = 0; r < N_RANKS; r++) begin : g_rank
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      logic hit;
      logic close;

      assign hit   = rank_sel[r] && (c0_ddr3_ba == 3'(b));
      // PRE closes the addressed bank, or every bank of the rank with A10;
      // RD/WR with A10 is auto-precharge and closes only its own bank.
      assign close = (rank_sel[r] && is_pre && (a10 || (c0_ddr3_ba == 3'(b))))
                   || (hit && is_rw && a10);

      ddr3_mon_bank #(
        .T_RCD (T_RCD),
        .T_RP  (T_RP)
      ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .cmd_act       (hit && is_act),
        .cmd_rw        (hit && is_rw),
        .cmd_close     (close),
        .upd_en        (upd_en),
        .is_open       (open_q[r][b]),
        .err_act_open  (c_act_open[r][b]),
        .err_act_trp   (c_act_trp[r][b]),
        .err_rw_closed (c_rw_closed[r][b]),
        .err_rw_trcd   (c_rw_trcd[r][b])
      );

      assign bank_open[r*N_BANKS+b] = open_q[r][b];
    end
  end

  // --------------------------------------------------------- refresh timers
  logic [TIMER_W-1:0] rfc_tmr [N_RANKS];

  // Per-rank cycles-since-REF, saturating so an idle rank is always legal.
  always_ff @(posedge clk) begin
    for (int r = 0; r < N_RANKS; r++) begin
      if (rst) begin
        rfc_tmr[r] <= TIMER_MAX;
      end else if (rank_sel[r] && is_ref) begin
        rfc_tmr[r] <= '0;
      end else begin
        rfc_tmr[r] <= timer_next(rfc_tmr[r]);
      end
    end
  end

  // -------------------------------------------------------- priority select
  ddr3_err_e  err_n;
  logic       err_rank_n;
  logic [2:0] err_bank_n;
  ddr3_err_e  code_r;
  logic [2:0] bank_r;

  // Lowest selected rank with any violation wins; within a rank, lowest code.
  always_comb begin
    err_n      = ERR_NONE;
    err_rank_n = 1'b0;
    err_bank_n = '0;
    code_r     = ERR_NONE;
    bank_r     = '0;
    for (int r = 0; r < N_RANKS; r++) begin
      if (err_n == ERR_NONE && rank_sel[r]) begin
        code_r = ERR_NONE;
        bank_r = c0_ddr3_ba;
        if (multi_cs) begin
          code_r = ERR_MULTI_CS;
        end else if (!is_nop && (timer_next(rfc_tmr[r]) < RFC_LIM)) begin
          code_r = ERR_IN_TRFC;
        end else if (c_act_open[r][c0_ddr3_ba]) begin
          code_r = ERR_ACT_OPEN;
        end else if (c_act_trp[r][c0_ddr3_ba]) begin
          code_r = ERR_ACT_TRP;
        end else if (c_rw_closed[r][c0_ddr3_ba]) begin
          code_r = ERR_RW_CLOSED;
        end else if (c_rw_trcd[r][c0_ddr3_ba]) begin
          code_r = ERR_RW_TRCD;
        end else if (is_ref && (|open_q[r])) begin
          code_r = ERR_REF_OPEN;
          bank_r = lowest_bank(8'(open_q[r]));
        end
        if (code_r != ERR_NONE) begin
          err_n      = code_r;
          err_rank_n = 1'(r);
          err_bank_n = bank_r;
        end
      end
    end
  end

  // Error report register: one pulse per offending command.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= '0;
      err_rank  <= 1'b0;
      err_bank  <= '0;
    end else begin
      err_valid <= (err_n != ERR_NONE);
      err_code  <= err_n;
      err_rank  <= err_rank_n;
      err_bank  <= err_bank_n;
    end
  end

  // ---------------------------------------------------------------- counters
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + {1'b0, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] act_cnt_q, rd_cnt_q, wr_cnt_q, ref_cnt_q;
  logic [CNT_W-1:0] act_inc, rd_inc, wr_inc, ref_inc;

  assign act_inc = (is_act && upd_en)                    ? n_sel : '0;
  assign rd_inc  = ((bus_cmd == CMD_RD) && upd_en)       ? n_sel : '0;
  assign wr_inc  = ((bus_cmd == CMD_WR) && upd_en)       ? n_sel : '0;
  assign ref_inc = is_ref                                ? n_sel : '0;

  // Saturating traffic counters, one step per selected rank.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ref_cnt_q <= '0;
    end else begin
      act_cnt_q <= sat_add(act_cnt_q, act_inc);
      rd_cnt_q  <= sat_add(rd_cnt_q, rd_inc);
      wr_cnt_q  <= sat_add(wr_cnt_q, wr_inc);
      ref_cnt_q <= sat_add(ref_cnt_q, ref_inc);
    end
  end

  assign act_cnt = act_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign ref_cnt = ref_cnt_q;

endmodule

// File: doc/ddr3_cmd_monitor.md
Name: ddr3_cmd_monitor

Overview:
- Simulation-side protocol monitor that watches the DDR3 command/address bus driven by the memory controller into the DIMM model.
- Decodes commands per rank, tracks per-bank open/closed state and timing, counts traffic, and flags protocol violations.
- Passive and non-synthesized: it samples the bus and drives no DIMM pins.

Parameters:
- N_RANKS, 2, number of chip selects monitored.
- N_BANKS, 8, banks per rank; bank address width is 3.
- T_RCD, 11, minimum cycles from ACT to RD/WR on the same bank.
- T_RP, 11, minimum cycles from PRE to ACT on the same bank.
- T_RFC, 208, minimum cycles from REF to any non-NOP command on the same rank.
- CNT_W, 32, width of the traffic counters.

Ports:
- clk  in  1  DDR command clock.
- rst  in  1  synchronous, active-high reset.
- c0_ddr3_addr  in  16  row/column address; bit 10 is A10 (auto-precharge / precharge-all).
- c0_ddr3_ba  in  3  bank address.
- c0_ddr3_ras_n  in  1  RAS_n.
- c0_ddr3_cas_n  in  1  CAS_n.
- c0_ddr3_we_n  in  1  WE_n.
- c0_ddr3_cke  in  N_RANKS  clock enable, per rank.
- c0_ddr3_cs_n  in  N_RANKS  chip select, per rank, active low.
- err_valid  out  1  one-cycle pulse when a violation is detected.
- err_code  out  3  violation code; see Behaviour.
- err_rank  out  1  rank of the reported violation.
- err_bank  out  3  bank of the reported violation.
- bank_open  out  N_RANKS*N_BANKS  open flag per bank, index rank*8+bank.
- act_cnt, rd_cnt, wr_cnt, ref_cnt  out  CNT_W each  saturating command counters.

Behaviour:
- Clocking/reset: single clock, reset is synchronous and active-high. While rst=1 (sampled at clk):
  - all outputs are 0 and all banks are closed;
  - every per-bank timer and per-rank refresh timer is loaded with its saturated ("satisfied") value.
- Reset mid-operation discards all state; the first command after reset deasserts is checked against a clean state.
- Decode: a rank is selected when cs_n[r]=0 and cke[r]=1. Codes as {ras_n,cas_n,we_n}:
  - ACT=011, RD=101, WR=100, PRE=010, REF=001, MRS=000, ZQ=110, NOP=111.
  - A rank with cs_n[r]=1 sees NOP.
- Bank state updates, per selected rank:
  - ACT opens ba and clears its ACT timer.
  - PRE with A10=0 closes ba and clears its PRE timer; PRE with A10=1 does the same for all banks of the rank.
  - RD/WR with A10=1 closes the bank after the check and clears its PRE timer.
  - REF clears the rank's refresh timer.
  - MRS/ZQ: no bank effect.
- Timers: increment each cycle and saturate at 255. Width is 8 bits, so T_RFC is capped at 255.
- Error codes, highest priority first:
  - 1 MULTI_CS: ACT/RD/WR with more than one rank selected.
  - 2 IN_TRFC: non-NOP while refresh timer < T_RFC.
  - 3 ACT_OPEN: ACT to an open bank.
  - 4 ACT_TRP: ACT while PRE timer < T_RP.
  - 5 RW_CLOSED: RD/WR to a closed bank.
  - 6 RW_TRCD: RD/WR while ACT timer < T_RCD.
  - 7 REF_OPEN: REF with any bank of that rank open.
- Error reporting:
  - At most one error is reported per cycle. Ties go to the lowest rank, then to the code priority above.
  - The state update still happens after an error (the command is assumed to have taken effect). Exception: MULTI_CS suppresses the state update for that command.
- Latency: every output is registered and reflects the bus sampled one cycle earlier. err_valid is high for exactly one cycle per offending command.
- Counters: increment once per command per selected rank (ACT/RD/WR/REF) and saturate at all-ones, never wrapping. A REF to two ranks in the same cycle adds 2.
- Boundary timing:
  - A command exactly T_RCD (or T_RP) cycles after its enabling command is legal; one cycle earlier is a violation.
  - Back-to-back ACT/PRE/ACT on the same bank is checked against the newest timer only.

Decomposition:
- Package ddr3_mon_pkg holds:
  - the ddr3_cmd_e enum (3-bit {ras_n,cas_n,we_n} encoding);
  - the ddr3_err_e enum (codes 0..7);
  - default timing constants for sg125 (tCK 1.25 ns): T_RCD=11, T_RP=11, T_RFC=208;
  - the TIMER_MAX=255 constant.
- Sub-module ddr3_mon_bank is instantiated N_RANKS*N_BANKS times. It owns the open flag, ACT timer and PRE timer, and emits its per-bank error candidates.
- The top level does decode, refresh timers, priority select, counters and output registers.

Test Plan:
- ACT r0 b2 row 0x1A5, 11 NOPs, RD b2 -> no error; rd_cnt=1; bank_open[2]=1.
- ACT r0 b3, RD b3 after 10 cycles -> err_valid one cycle later; err_code=6, err_rank=0, err_bank=3.
- ACT r1 b0, then ACT r1 b0 again -> err_code=3, err_rank=1, err_bank=0. PRE with A10=1 on r1 -> bank_open[15:8]=0.
- REF r0, MRS at +100 cycles -> err_code=2. Repeat with MRS at +208 cycles -> no error; ref_cnt=2.
- ACT with cs_n=2'b00 -> err_code=1 and bank_open unchanged. WR to a closed bank on r0 -> err_code=5.
- Preload act_cnt to 0xFFFFFFFE (bench force), issue 3 ACTs, then pulse rst mid-sequence -> counter holds 0xFFFFFFFF; after reset all counters and bank_open are 0.
